// File: rtl/spi_out_arbiter.sv
// spi_out_arbiter: round-robin sharing of one SPI master among NREQ requesters,
// holding the winner's word, enforcing an idle gap and aborting if cs never drops.
module spi_out_arbiter #(
    parameter int BITS    = 4,
    parameter int NREQ    = 2,
    parameter int GAP     = 2,
    parameter int TIMEOUT = 8,
    localparam int IW     = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NREQ-1:0]      i_req,
    input  logic [NREQ*BITS-1:0] i_req_data,
    output logic [NREQ-1:0]      o_ack,
    output logic [NREQ-1:0]      o_done,
    output logic                 o_err,
    output logic                 o_busy,
    output logic [IW-1:0]        o_grant_id,
    output logic                 o_spi_start,
    output logic [BITS-1:0]      o_spi_data,
    input  logic                 i_spi_cs
);
    typedef enum logic [2:0] {IDLE, START, WAIT_LO, WAIT_HI, GAPS} state_t;
    localparam state_t POST = (GAP == 0) ? IDLE : GAPS;

    state_t            r_state, w_state_n;
    logic [IW-1:0]     r_rr, w_pick, w_rr_n;
    logic [7:0]        r_timer, r_gap;
    logic [2*NREQ-1:0] w_rot;
    logic [IW:0]       w_sum;
    logic [BITS-1:0]   w_word;
    logic [NREQ-1:0]   w_ack_n, w_done_n;
    logic              w_grant, w_timeout, w_err_n, w_start_n;

    // Rotating the doubled request vector puts the rr pointer at bit 0.
    assign w_rot     = {i_req, i_req} >> r_rr;
    assign w_grant   = r_state == IDLE && i_spi_cs && |i_req;
    assign w_timeout = r_state == WAIT_LO && i_spi_cs && r_timer == 8'(TIMEOUT - 1);
    assign w_rr_n    = (w_pick == IW'(NREQ - 1)) ? '0 : w_pick + IW'(1);

    always_comb begin
        w_pick = '0;
        w_sum  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr} + (IW + 1)'(k);
            if (w_sum >= (IW + 1)'(NREQ)) w_sum = w_sum - (IW + 1)'(NREQ);
            if (w_rot[k]) w_pick = w_sum[IW-1:0];
        end
    end

    always_comb begin
        w_word = '0;
        for (int i = 0; i < NREQ; i++)
            if (w_pick == IW'(i)) w_word = i_req_data[i*BITS +: BITS];
    end

    always_ff @(posedge i_clk or posedge i_reset)
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_n;

    always_comb begin
        w_state_n = r_state;
        case (r_state)
            IDLE:    w_state_n = w_grant ? START : IDLE;
            START:   w_state_n = WAIT_LO;
            WAIT_LO: w_state_n = !i_spi_cs ? WAIT_HI : (w_timeout ? POST : WAIT_LO);
            WAIT_HI: w_state_n = i_spi_cs ? POST : WAIT_HI;
            GAPS:    w_state_n = (r_gap == 8'(GAP - 1)) ? IDLE : GAPS;
            default: w_state_n = IDLE;
        endcase
    end

    always_comb begin
        w_ack_n   = w_grant ? NREQ'(1) << w_pick : '0;
        w_done_n  = (r_state == WAIT_HI && i_spi_cs) ? NREQ'(1) << o_grant_id : '0;
        w_err_n   = w_timeout;
        w_start_n = r_state == START;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_ack       <= '0;
            o_done      <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_grant_id  <= '0;
            o_spi_start <= 1'b0;
            o_spi_data  <= '0;
            r_rr        <= '0;
            r_timer     <= '0;
            r_gap       <= '0;
        end else begin
            o_ack       <= w_ack_n;
            o_done      <= w_done_n;
            o_err       <= w_err_n;
            o_spi_start <= w_start_n;
            o_busy      <= w_state_n != IDLE;
            if (w_grant) begin
                o_grant_id <= w_pick;
                o_spi_data <= w_word;
                r_rr       <= w_rr_n;
            end
            r_timer <= (r_state == START) ? 8'd0 :
                       (r_state == WAIT_LO && r_timer != 8'hFF) ? r_timer + 8'd1 : r_timer;
            r_gap   <= (r_state != GAPS) ? 8'd0 : (r_gap != 8'hFF) ? r_gap + 8'd1 : r_gap;
        end
    end
endmodule

// File: tb/tb_spi_out_arbiter.sv
// tb_spi_out_arbiter: scoreboard bench for spi_out_arbiter with a behavioural SPI
// master driving cs low for BITS cycles after each start.
module tb_spi_out_arbiter;
    localparam int BITS = 4, NREQ = 2, GAP = 2, TIMEOUT = 8;

    logic       clk = 1'b0, reset = 1'b1, spi_cs = 1'b1;
    logic [1:0] req = '0;
    logic [7:0] req_data = '0;
    logic [1:0] o_ack, o_done;
    logic       o_err, o_busy, o_spi_start;
    logic [0:0] o_grant_id;
    logic [3:0] o_spi_data;

    int n_chk = 0, n_fail = 0, cyc = 0;
    int q_id[$];
    logic [3:0] q_data[$];

    spi_out_arbiter #(.BITS(BITS), .NREQ(NREQ), .GAP(GAP), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_reset(reset), .i_req(req), .i_req_data(req_data),
        .o_ack(o_ack), .o_done(o_done), .o_err(o_err), .o_busy(o_busy),
        .o_grant_id(o_grant_id), .o_spi_start(o_spi_start), .o_spi_data(o_spi_data),
        .i_spi_cs(spi_cs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input int id, input logic [3:0] d);
        q_id.push_back(id);
        q_data.push_back(d);
    endtask

    task automatic grant_check(input logic drop, output int t_ack);
        int n, id;
        logic [3:0] d;
        n = 0;
        do begin @(negedge clk); n++; end while (o_ack == 0 && n < 30);
        t_ack = cyc;
        if (o_ack == 0) chk("ack_seen", 0, 1);
        else if (q_id.size() == 0) chk("sb_nonempty", 0, 1);
        else begin
            id = q_id.pop_front();
            d  = q_data.pop_front();
            chk("ack_vec", 32'(o_ack), 32'(1) << id);
            chk("grant_id", 32'(o_grant_id), id);
            chk("spi_data", 32'(o_spi_data), 32'(d));
            if (drop) req = '0;
        end
    endtask

    task automatic frame(input logic drop, output int t_ack, output int t_done);
        int extra;
        logic [3:0] d;
        logic [0:0] id;
        grant_check(drop, t_ack);
        d  = o_spi_data;
        id = o_grant_id;
        @(negedge clk);
        chk("spi_start", 32'(o_spi_start), 1);
        extra  = 0;
        spi_cs = 1'b0;
        repeat (BITS) begin
            @(negedge clk);
            extra += int'(o_ack != 0) + int'(o_spi_start) + int'(o_err) + int'(o_done != 0);
        end
        chk("data_hold", 32'(o_spi_data), 32'(d));
        spi_cs = 1'b1;
        @(negedge clk);
        t_done = cyc;
        chk("done_vec", 32'(o_done), 32'(1) << id);
        chk("frame_quiet", extra, 0);
    endtask

    task automatic busy_cycles(output int n);
        n = 0;
        while (o_busy && n < 40) begin @(negedge clk); n++; end
    endtask

    initial begin
        int ta, td, tp, t0, n, dn;
        repeat (3) @(negedge clk);
        chk("rst_outs", {o_ack, o_done, o_err, o_busy, o_grant_id, o_spi_start, o_spi_data}, 0);
        reset = 1'b0;
        @(negedge clk);

        // single request
        req_data = {4'h0, 4'hA};
        push(0, 4'hA);
        req = 2'b01;
        t0 = cyc;
        frame(1'b1, ta, td);
        chk("ack_latency", ta - t0, 1);
        busy_cycles(n);
        chk("single_gap", n, GAP);
        n = 0;
        repeat (4) begin @(negedge clk); n += int'(o_ack != 0); end
        chk("single_no_regrant", n, 0);

        // contention from a fresh rr pointer
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_data = {4'hC, 4'h3};
        for (int i = 0; i < 4; i++) push(i % 2, (i % 2) ? 4'hC : 4'h3);
        req = 2'b11;
        tp = 0;
        for (int i = 0; i < 4; i++) begin
            frame(i == 3, ta, td);
            if (i > 0) chk("gap_ack", ta - tp, GAP + 1);
            tp = td;
        end
        busy_cycles(n);

        // start timeout with cs stuck high
        req_data = {4'hC, 4'h5};
        push(0, 4'h5);
        req = 2'b01;
        grant_check(1'b1, ta);
        @(negedge clk);
        chk("to_start", 32'(o_spi_start), 1);
        t0 = cyc;
        n = 0;
        dn = 0;
        while (!o_err && n < 40) begin @(negedge clk); n++; dn += int'(o_done != 0); end
        chk("err_latency", cyc - t0, TIMEOUT);
        chk("err_no_done", dn, 0);
        busy_cycles(n);
        chk("err_gap", n, GAP);

        // asynchronous reset while in WAIT_HI
        req_data = {4'hC, 4'hA};
        push(0, 4'hA);
        req = 2'b01;
        grant_check(1'b1, ta);
        @(negedge clk);
        spi_cs = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", 32'(o_busy), 1);
        #2 reset = 1'b1;
        #1 chk("async_rst", {o_ack, o_done, o_err, o_busy, o_grant_id, o_spi_start, o_spi_data}, 0);
        @(negedge clk);
        reset  = 1'b0;
        spi_cs = 1'b1;
        @(negedge clk);
        req_data = {4'hC, 4'h3};
        push(0, 4'h3);
        req = 2'b11;
        frame(1'b1, ta, td);
        busy_cycles(n);

        // foreign traffic blocks the grant
        spi_cs = 1'b0;
        push(1, 4'hC);
        req = 2'b10;
        n = 0;
        repeat (5) begin @(negedge clk); n += int'(o_ack != 0); end
        chk("blocked_no_ack", n, 0);
        t0 = cyc;
        spi_cs = 1'b1;
        frame(1'b1, ta, td);
        chk("unblock_latency", ta - t0, 1);
        busy_cycles(n);
        chk("sb_drained", q_id.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
